vmx_ws_array: RTL and testbench

VMX_WS_ARRAY -- requirements
Module: vmx_ws_array

---
 rtl/vmx_pkg.sv | 15 +
 rtl/vmx_ws_pe.sv | 50 +++++
 rtl/vmx_ws_array.sv | 164 ++++++++++++++++
 tb/tb_vmx_ws_array.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmx_pkg.sv
// Shared definitions for the weight-stationary matrix-vector array.
package vmx_pkg;

  localparam int unsigned DefRows  = 4;
  localparam int unsigned DefCols  = 4;
  localparam int unsigned DefDataW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } vmx_state_e;

endpackage

// File: rtl/vmx_ws_pe.sv
// Processing element: stationary weight, activation pass-through to the right,
// multiply-accumulate of the partial sum flowing down.
module vmx_ws_pe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sgn,
  input  logic              w_we,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] act_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] act_out,
  output logic [ACC_W-1:0]  psum_out
);

  logic [DATA_W-1:0] weight_q, act_q;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic [ACC_W-1:0]  act_ext, w_ext;

  // Low ACC_W bits of the product are the same for signed and unsigned once
  // both operands are extended to ACC_W.
  always_comb begin
    act_ext = sgn ? {{(ACC_W-DATA_W){act_in[DATA_W-1]}}, act_in}
                  : {{(ACC_W-DATA_W){1'b0}}, act_in};
    w_ext   = sgn ? {{(ACC_W-DATA_W){weight_q[DATA_W-1]}}, weight_q}
                  : {{(ACC_W-DATA_W){1'b0}}, weight_q};
    psum_d  = psum_in + act_ext * w_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q <= '0;
      act_q    <= '0;
      psum_q   <= '0;
    end else begin
      if (w_we) weight_q <= w_in;
      if (en) begin
        act_q  <= act_in;
        psum_q <= psum_d;
      end
    end
  end

  assign act_out  = act_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/vmx_ws_array.sv
// Weight-stationary systolic array computing out = in * W with a stall-able
// pipeline of fixed latency ROWS+COLS.
module vmx_ws_array
  import vmx_pkg::*;
#(
  parameter int unsigned ROWS   = DefRows,
  parameter int unsigned COLS   = DefCols,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sgn,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [COLS*DATA_W-1:0] w_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*ACC_W-1:0]  out_data,
  input  logic                   flush,
  output logic                   busy
);

  localparam int unsigned LAT  = ROWS + COLS;
  localparam int unsigned CntW = $clog2(LAT + 1);
  localparam int unsigned WcW  = $clog2(ROWS + 1);

  vmx_state_e state_q, state_d;
  logic [WcW-1:0]  wcnt_q, wcnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sgn_q;
  logic [LAT-1:0]  vld_q;
  logic [COLS*ACC_W-1:0] out_data_q, res_flat;

  logic stall, en, w_fire, in_fire, out_fire;
  logic [ROWS-1:0] row_we;

  logic [DATA_W-1:0] act_chain  [ROWS][COLS+1];
  logic [ACC_W-1:0]  psum_chain [ROWS+1][COLS];

  assign out_valid = vld_q[LAT-1];
  assign out_data  = out_data_q;
  assign stall     = out_valid & ~out_ready;
  assign en        = ~stall;
  assign w_ready   = (state_q == StIdle) || (state_q == StLoad);
  assign in_ready  = (state_q == StRun) & ~stall;
  assign busy      = state_q != StIdle;
  assign w_fire    = w_valid & w_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle, StLoad: begin
        if (w_fire) begin
          if (wcnt_q == WcW'(ROWS - 1)) begin
            wcnt_d  = '0;
            state_d = StRun;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StRun:   if (flush) state_d = StDrain;
      StDrain: if (cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case ({in_fire, out_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    for (int r = 0; r < ROWS; r++) row_we[r] = w_fire && (wcnt_q == WcW'(r));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      sgn_q      <= 1'b0;
      vld_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      if (w_fire && state_q == StIdle) sgn_q <= sgn;
      if (en) begin
        vld_q      <= {vld_q[LAT-2:0], in_fire};
        // Idle slots present zero so out_data stays clean when out_valid is low.
        out_data_q <= vld_q[LAT-2] ? res_flat : '0;
      end
    end
  end

  // Input skew: row r enters the array r cycles late.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign act_chain[r][0] = in_data[r*DATA_W +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] dly_q [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < r; k++) dly_q[k] <= '0;
        end else if (en) begin
          dly_q[0] <= in_data[r*DATA_W +: DATA_W];
          for (int k = 1; k < r; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign act_chain[r][0] = dly_q[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      vmx_ws_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sgn      (sgn_q),
        .w_we     (row_we[r]),
        .w_in     (w_data[c*DATA_W +: DATA_W]),
        .act_in   (act_chain[r][c]),
        .psum_in  (psum_chain[r][c]),
        .act_out  (act_chain[r][c+1]),
        .psum_out (psum_chain[r+1][c])
      );
    end
  end

  // Output deskew: column c waits COLS-1-c cycles so all columns line up.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int unsigned Depth = COLS - 1 - c;
    assign psum_chain[0][c] = '0;
    if (Depth == 0) begin : g_direct
      assign res_flat[c*ACC_W +: ACC_W] = psum_chain[ROWS][c];
    end else begin : g_dly
      logic [ACC_W-1:0] dly_q [Depth];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < Depth; k++) dly_q[k] <= '0;
        end else if (en) begin
          dly_q[0] <= psum_chain[ROWS][c];
          for (int k = 1; k < Depth; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign res_flat[c*ACC_W +: ACC_W] = dly_q[Depth-1];
    end
  end

endmodule

// File: tb/tb_vmx_ws_array.sv
// Randomized bench for vmx_ws_array with a matrix-vector reference model and
// a latency/order scoreboard.
module tb_vmx_ws_array;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(ROWS);
  localparam int unsigned LAT    = ROWS + COLS;

  logic clk = 1'b0;
  logic rst, sgn, w_valid, w_ready, in_valid, in_ready, out_valid, out_ready, flush, busy;
  logic [COLS*DATA_W-1:0] w_data;
  logic [ROWS*DATA_W-1:0] in_data;
  logic [COLS*ACC_W-1:0]  out_data;

  vmx_ws_array #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sgn       (sgn),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COLS*ACC_W-1:0] data;
    int                    tag;
    bit                    seen;
  } exp_t;

  exp_t sb[$];
  logic [DATA_W-1:0] m_w [ROWS][COLS];
  bit   m_sgn;
  int   checks = 0;
  int   errors = 0;
  int   edge_idx = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: out[c] = sum_r ext(in[r]) * ext(W[r][c]) mod 2^ACC_W.
  function automatic logic [COLS*ACC_W-1:0] model(input logic [ROWS*DATA_W-1:0] v);
    logic [COLS*ACC_W-1:0] res;
    logic [DATA_W-1:0] e, we;
    longint acc, a, w;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++) begin
        e  = v[r*DATA_W +: DATA_W];
        we = m_w[r][c];
        a  = m_sgn ? longint'($signed(e)) : longint'(e);
        w  = m_sgn ? longint'($signed(we)) : longint'(we);
        acc += a * w;
      end
      res[c*ACC_W +: ACC_W] = acc[ACC_W-1:0];
    end
    return res;
  endfunction

  function automatic logic [ROWS*DATA_W-1:0] pack4(input int a, input int b, input int c,
                                                   input int d);
    logic [DATA_W-1:0] x0, x1, x2, x3;
    x0 = DATA_W'(a); x1 = DATA_W'(b); x2 = DATA_W'(c); x3 = DATA_W'(d);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [ROWS*DATA_W-1:0] rand_vec();
    logic [ROWS*DATA_W-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  // Scoreboard: checks order, data, exact latency in enabled cycles and stall stability.
  logic [COLS*ACC_W-1:0] prev_data;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          if (!sb[0].seen) begin
            check("latency", edge_idx, sb[0].tag + LAT);
            sb[0].seen = 1'b1;
          end else if (prev_stall) begin
            check("stall_hold", out_data, prev_data);
          end
          check("out_data", out_data, sb[0].data);
        end
      end else if (sb.size() > 0 && edge_idx >= sb[0].tag + int'(LAT)) begin
        check("missing_out_valid", out_valid, 1'b1);
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) sb.push_back('{data: model(in_data), tag: edge_idx, seen: 1'b0});
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (!(out_valid && !out_ready)) edge_idx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic load(input bit s);
    m_sgn = s;
    sgn   = s;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) w_data[c*DATA_W +: DATA_W] = m_w[r][c];
      w_valid = 1'b1;
      check("w_ready_load", w_ready, 1'b1);
      tick();
      sgn = ~s;  // later beats must not change the latched signedness
    end
    w_valid = 1'b0;
    check("in_ready_run", in_ready, 1'b1);
    check("busy_run", busy, 1'b1);
  endtask

  task automatic send(input logic [ROWS*DATA_W-1:0] v, input bit with_flush);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    if (with_flush) flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_in_ready", in_ready, 1'b0);
    check("drain_busy", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("idle_busy", busy, 1'b0);
    check("idle_w_ready", w_ready, 1'b1);
    check("idle_pending", sb.size(), 0);
  endtask

  task automatic rand_weights();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_w[r][c] = DATA_W'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_ready"}, w_ready, 1'b1);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sgn = 1'b0; w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; flush = 1'b0;
    repeat (3) tick();
    check_reset_outputs("in_reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("after_reset");

    // Identity weights, unsigned.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_w[r][c] = (r == c) ? 8'd1 : 8'd0;
    load(1'b0);
    send(pack4(1, 2, 3, 4), 1'b0);
    do_flush();
    wait_idle();

    // All -1 weights, signed, including the most negative operand.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_w[r][c] = 8'hFF;
    load(1'b1);
    send(pack4(127, -128, 1, 0), 1'b0);
    send(pack4(-128, -128, -128, -128), 1'b0);
    do_flush();
    wait_idle();

    // Ten back-to-back vectors under the 1,0,0,1 out_ready pattern.
    rand_weights();
    load(1'($urandom_range(0, 1)));
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) send(rand_vec(), 1'b0);
    do_flush();
    wait_idle();
    rdy_mode = 0;

    // Flush on the same cycle as the third input: three results drain.
    rand_weights();
    load(1'b1);
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b1);
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_busy", busy, 1'b1);
    wait_idle();

    // Weight beats during RUN are ignored.
    rand_weights();
    load(1'b0);
    w_valid = 1'b1;
    w_data  = COLS*DATA_W'($urandom);
    tick();
    check("run_w_ready", w_ready, 1'b0);
    for (int i = 0; i < 4; i++) send(rand_vec(), 1'b0);
    check("run_w_ready_late", w_ready, 1'b0);
    w_valid = 1'b0;
    do_flush();
    wait_idle();

    // Random traffic: random gaps and random out_ready.
    rand_weights();
    load(1'($urandom_range(0, 1)));
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(rand_vec(), 1'b0);
    end
    do_flush();
    wait_idle();
    rdy_mode = 0;

    // Reset with five results in flight: none of them may appear.
    rand_weights();
    load(1'b1);
    for (int i = 0; i < 5; i++) send(rand_vec(), 1'b0);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_reset_out_valid", out_valid, 1'b0);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_w[r][c] = '0;
    load(1'b0);
    send(rand_vec(), 1'b0);
    do_flush();
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
